// File: rtl/demux_stream_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants for the demux_stream slice.
//   N_CH_DEF / DATA_W_DEF : default channel count and payload width.
//   ST_EMPTY / ST_FULL    : encoding of the one-deep output register state.
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int   N_CH_DEF   = 16;
    localparam int   DATA_W_DEF = 8;

    localparam logic ST_EMPTY   = 1'b0;
    localparam logic ST_FULL    = 1'b1;

endpackage

// File: rtl/demux_stream_onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
// Combinational binary-to-one-hot decoder used to form the per-channel valid
// vector from the held destination index and the "register full" flag.
// Ports:
//   idx    in  W  binary channel index
//   en     in  1  decoder enable (all outputs low when 0)
//   onehot out N  one-hot decode of idx, gated by en
// -----------------------------------------------------------------------------
module onehot_dec #(
    parameter  int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [W-1:0] idx,
    input  logic         en,
    output logic [N-1:0] onehot
);

    // Decode idx into a single asserted bit when enabled.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (idx == W'(i))) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux_stream.sv
// -----------------------------------------------------------------------------
// demux_stream
// 1-to-N_CH stream demultiplexer with a registered one-deep output stage,
// valid/ready on the input and on every output lane, explicit-select or
// round-robin distribution and sticky out-of-range select detection.
//
// Optional feature: define DEMUX_STREAM_BCAST_EN to add the 'bcast' input.
// A beat accepted with bcast=1 is offered to every lane at once; each lane's
// valid bit retires independently when that lane is ready.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-high reset
//   mode       in   1       0 = explicit select, 1 = round-robin
//   in_sel     in   SEL_W   destination lane when mode=0
//   in_valid   in   1       producer beat valid
//   in_data    in   DATA_W  producer payload
//   in_ready   out  1       beat accepted this cycle when in_valid is high
//   out_valid  out  N_CH    per-lane valid (one-hot, or all-ones on broadcast)
//   out_data   out  DATA_W  shared payload bus
//   out_ready  in   N_CH    per-lane consumer ready
//   cur_dest   out  SEL_W   destination of the held beat
//   rr_ptr     out  SEL_W   next round-robin destination
//   sel_err    out  1       sticky out-of-range select flag
//   bcast      in   1       (DEMUX_STREAM_BCAST_EN only) broadcast this beat
// -----------------------------------------------------------------------------
module demux_stream
    import demux_pkg::*;
#(
    parameter  int N_CH   = N_CH_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [N_CH-1:0]   out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [N_CH-1:0]   out_ready,
    output logic [SEL_W-1:0]  cur_dest,
    output logic [SEL_W-1:0]  rr_ptr,
    output logic              sel_err
`ifdef DEMUX_STREAM_BCAST_EN
    ,
    input  logic              bcast
`endif
);

    // N_CH widened by one bit so an in_sel compare never truncates it.
    localparam logic [SEL_W:0]   N_CH_L  = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] RR_LAST = SEL_W'(N_CH - 1);

    logic              state_r,   state_nx_s;
    logic [DATA_W-1:0] data_r,    data_nx_s;
    logic [SEL_W-1:0]  dest_r,    dest_nx_s;
    logic [SEL_W-1:0]  rr_r,      rr_nx_s;
    logic              err_r,     err_nx_s;
    logic [N_CH-1:0]   bmask_r,   bmask_nx_s;
    logic              bactive_r, bactive_nx_s;

    logic              bc_s;
    logic              ready_s;
    logic              accept_s;
    logic              hs_s;
    logic              oor_s;
    logic [SEL_W-1:0]  tgt_s;
    logic [N_CH-1:0]   dec_valid_s;

`ifdef DEMUX_STREAM_BCAST_EN
    assign bc_s = bcast;
`else
    assign bc_s = 1'b0;
`endif

    // Input acceptance: free when empty, otherwise only when the held beat's
    // own lane takes it this cycle; never during a broadcast.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_EMPTY: ready_s = 1'b1;
            ST_FULL: begin
                if (bactive_r) begin
                    ready_s = 1'b0;
                end else begin
                    ready_s = out_ready[dest_r];
                end
            end
            default: ready_s = 1'b0;
        endcase
    end

    assign accept_s = in_valid && ready_s;
    assign hs_s     = (state_r == ST_FULL) && !bactive_r && out_ready[dest_r];
    assign tgt_s    = mode ? rr_r : in_sel;
    // Only reachable when N_CH is not a power of two.
    assign oor_s    = !mode && !bc_s && ({1'b0, in_sel} >= N_CH_L);

    // Next-state: retire the held beat (or broadcast bits), then load any
    // newly accepted beat on top so back-to-back transfers keep full rate.
    always_comb begin
        state_nx_s   = state_r;
        data_nx_s    = data_r;
        dest_nx_s    = dest_r;
        rr_nx_s      = rr_r;
        err_nx_s     = err_r;
        bmask_nx_s   = bmask_r;
        bactive_nx_s = bactive_r;

        if (bactive_r) begin
            bmask_nx_s = bmask_r & ~out_ready;
            if (bmask_nx_s == '0) begin
                bactive_nx_s = 1'b0;
                state_nx_s   = ST_EMPTY;
            end else begin
                state_nx_s   = ST_FULL;
            end
        end else if (hs_s) begin
            state_nx_s = ST_EMPTY;
        end else begin
            state_nx_s = state_r;
        end

        if (accept_s) begin
            if (bc_s) begin
                state_nx_s   = ST_FULL;
                data_nx_s    = in_data;
                dest_nx_s    = '0;
                bmask_nx_s   = '1;
                bactive_nx_s = 1'b1;
            end else if (oor_s) begin
                // Dropped beat: nothing is loaded, only the sticky flag moves.
                err_nx_s = 1'b1;
            end else begin
                state_nx_s = ST_FULL;
                data_nx_s  = in_data;
                dest_nx_s  = tgt_s;
                if (mode) begin
                    if (rr_r == RR_LAST) begin
                        rr_nx_s = '0;
                    end else begin
                        rr_nx_s = rr_r + SEL_W'(1);
                    end
                end else begin
                    rr_nx_s = rr_r;
                end
            end
        end else begin
            err_nx_s = err_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_EMPTY;
            data_r    <= '0;
            dest_r    <= '0;
            rr_r      <= '0;
            err_r     <= 1'b0;
            bmask_r   <= '0;
            bactive_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            data_r    <= data_nx_s;
            dest_r    <= dest_nx_s;
            rr_r      <= rr_nx_s;
            err_r     <= err_nx_s;
            bmask_r   <= bmask_nx_s;
            bactive_r <= bactive_nx_s;
        end
    end

    onehot_dec #(
        .N      (N_CH)
    ) u_dec (
        .idx    (dest_r),
        .en     ((state_r == ST_FULL) && !bactive_r),
        .onehot (dec_valid_s)
    );

    assign in_ready  = ready_s;
    assign out_valid = bactive_r ? bmask_r : dec_valid_s;
    assign out_data  = data_r;
    assign cur_dest  = dest_r;
    assign rr_ptr    = rr_r;
    assign sel_err   = err_r;

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Parametrised 1-to-N stream demultiplexer with valid/ready handshake on the input and on every output channel.
- Successor to the combinational 4-to-16 demux: adds a registered one-deep output stage, per-channel backpressure, a round-robin distribution mode and out-of-range select detection.
- Sits between a single producer and up to N_CH consumer lanes.

Parameters:
- N_CH, 16, number of output channels (2..256).
- DATA_W, 8, payload width in bits.
- SEL_W, $clog2(N_CH), select width (localparam, derived; not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = explicit select (in_sel), 1 = round-robin.
- in_sel  in  SEL_W  destination channel when mode=0; sampled with the beat.
- in_valid  in  1  producer beat valid.
- in_data  in  DATA_W  producer payload.
- in_ready  out  1  block accepts the beat this cycle.
- out_valid  out  N_CH  per-channel valid (one-hot, or all-ones with broadcast).
- out_data  out  DATA_W  shared payload bus, valid for any asserted out_valid bit.
- out_ready  in  N_CH  per-channel consumer ready.
- cur_dest  out  SEL_W  destination index of the held beat.
- rr_ptr  out  SEL_W  next round-robin destination.
- sel_err  out  1  sticky: an out-of-range select was accepted.

Behaviour:
- Reset values (asynchronous, immediate): out_valid=0, out_data=0, cur_dest=0, rr_ptr=0, sel_err=0, state=EMPTY.
- State machine, 2 states:
  - EMPTY: output register empty; in_ready=1.
  - FULL: one beat held; in_ready = out_ready[cur_dest].
- A beat is accepted when in_valid && in_ready.
- Destination: in_sel when mode=0; rr_ptr when mode=1.
- Latency: accepted beat appears on out_valid/out_data the next cycle.
- Channel handshake completes on out_valid[d] && out_ready[d]:
  - If a new beat is accepted in the same cycle, the block stays FULL with the new beat (back-to-back, full throughput).
  - Otherwise the block goes FULL -> EMPTY.
- Bits of out_ready for channels other than cur_dest are ignored.
- While FULL and stalled, out_data, cur_dest and out_valid are held stable.
- Round-robin:
  - rr_ptr increments on every accepted beat in mode=1.
  - Wraps from N_CH-1 to 0.
  - rr_ptr holds in mode=0.
  - A mode change takes effect on the next accepted beat; rr_ptr is not cleared.
- Out-of-range select (mode=0, in_sel >= N_CH; only possible when N_CH is not a power of 2):
  - Beat is accepted and dropped; no out_valid asserted; state unchanged.
  - sel_err sets and remains set until rst.
- in_valid deasserted while EMPTY: no state change.
- Reset mid-transfer: the held beat is discarded and all outputs return to reset values.

Optional Feature:
- Macro: DEMUX_STREAM_BCAST_EN.
- Defined:
  - Adds input port bcast (1 bit), sampled with the beat. A beat accepted with bcast=1 drives out_valid to all N_CH ones.
  - Each bit clears independently when its out_ready is seen. The block returns to EMPTY when all bits are clear.
  - in_ready=0 until the last bit clears, so no overlap with broadcast.
  - rr_ptr does not advance on a broadcast beat.
  - cur_dest is held at 0 during a broadcast.
- Undefined: no bcast port; behaviour as above.

Decomposition:
- Package demux_pkg:
  - localparam defaults: N_CH_DEF=16, DATA_W_DEF=8.
  - State encoding constants: ST_EMPTY=1'b0, ST_FULL=1'b1.
- Sub-module onehot_dec (parameter N): combinational binary-to-one-hot decoder producing out_valid from cur_dest and the full flag.

Test Plan:
- Reset and mode=0 sweep: rst pulse with out_ready=16'hFFFF, then send in_sel=0..15 with data 8'h10+i -> out_valid = 1<<i with out_data=8'h10+i one cycle after each accept; sel_err=0.
- Backpressure: in_sel=5, data 8'hA5, out_ready[5]=0 for 4 cycles -> out_valid=16'h0020 and data stable; in_ready=0; second beat is accepted only in the cycle out_ready[5] rises.
- Round-robin wrap: mode=1, 18 beats with out_ready all ones -> destinations 0..15,0,1; rr_ptr=2 at the end.
- Out-of-range select: N_CH=10, in_sel=12 -> beat accepted, no out_valid, sel_err=1 and remains set after further legal beats.
- Reset mid-transfer: assert rst while FULL with out_ready=0 -> out_valid=0 immediately (asynchronously), state EMPTY after release.
- Broadcast (DEMUX_STREAM_BCAST_EN): bcast=1, data 8'h3C, out_ready bits asserted one channel per cycle -> out_valid bits clear individually; in_ready=1 only after channel 15 accepts.
